// File: rtl/or_reduce_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | or_pkg: shared sizing helpers and defaults for or_reduce_pipe              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package or_pkg;

  localparam int OR_WIDTH_DEF            = 16;
  localparam int OR_LEVELS_PER_STAGE_DEF = 2;

  function automatic int or_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int or_num_stages(input int width, input int levels_per_stage);
    return (or_clog2(width) + levels_per_stage - 1) / levels_per_stage;
  endfunction

endpackage

`default_nettype wire

// File: rtl/or_reduce_pipe_if.sv
// +----------------------------------------------------------------------------+
// | or_reduce_pipe_if: valid/ready input vector and 1-bit reduced output       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface or_reduce_pipe_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_x;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_x,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_x,
    output out_valid,
    input  out_ready
  );

endinterface

`default_nettype wire

// File: rtl/or_reduce_pipe_stage.sv
// +----------------------------------------------------------------------------+
// | or_tree_stage: LEVELS levels of 2-input ORs followed by a registered,      |
// | bubble-collapsing valid/ready slot.  Revision: 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module or_tree_stage #(
  parameter  int IN_W   = 4,
  parameter  int LEVELS = 2,
  localparam int OUT_W  = ((IN_W >> LEVELS) < 1) ? 1 : (IN_W >> LEVELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [IN_W-1:0]  w_acc;
  logic             w_load;
  logic             valid_q;
  logic             valid_d;
  logic [OUT_W-1:0] data_q;
  logic [OUT_W-1:0] data_d;

  // In-place pairwise fold: level k overwrites the low IN_W>>k entries.
  always_comb begin
    w_acc = in_data_i;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int i = 0; i < IN_W / 2; i++) begin
        if (i < (IN_W >> k)) begin
          w_acc[i] = w_acc[2*i] | w_acc[2*i+1];
        end
      end
    end
  end

  assign w_load = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (w_load) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = w_acc[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = w_load;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/or_reduce_pipe.sv
// +----------------------------------------------------------------------------+
// | or_reduce_pipe: pipelined OR-reduction of a WIDTH-bit vector to one bit.   |
// | Optional sticky flag via OR_REDUCE_PIPE_STICKY_EN.  Revision: 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module or_reduce_pipe
  import or_pkg::*;
#(
  parameter int WIDTH            = OR_WIDTH_DEF,
  parameter int LEVELS_PER_STAGE = OR_LEVELS_PER_STAGE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  or_reduce_pipe_if.slave bus
`ifdef OR_REDUCE_PIPE_STICKY_EN
  ,
  input  logic          sticky_clr,
  output logic          sticky_x
`endif
);

  localparam int D = or_clog2(WIDTH);
  localparam int S = or_num_stages(WIDTH, LEVELS_PER_STAGE);
  localparam int P = 1 << D;

  // Zero padding up to a power of two never sets the OR result.
  logic [P-1:0] w_pad;
  assign w_pad = P'(bus.in_data);

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int LO    = s * LEVELS_PER_STAGE;
    localparam int LV    = ((D - LO) < LEVELS_PER_STAGE) ? (D - LO) : LEVELS_PER_STAGE;
    localparam int IN_W  = 1 << (D - LO);
    localparam int OUT_W = 1 << (D - LO - LV);

    logic [IN_W-1:0]  w_in;
    logic             w_in_vld;
    logic             w_in_rdy;
    logic [OUT_W-1:0] w_out;
    logic             w_out_vld;
    logic             w_out_rdy;

    if (s == 0) begin : g_head
      assign w_in         = w_pad;
      assign w_in_vld     = bus.in_valid;
      assign bus.in_ready = w_in_rdy;
    end else begin : g_link
      assign w_in     = g_stage[s-1].w_out;
      assign w_in_vld = g_stage[s-1].w_out_vld;
    end

    if (s == S - 1) begin : g_tail
      assign bus.out_x     = w_out[0];
      assign bus.out_valid = w_out_vld;
      assign w_out_rdy     = bus.out_ready;
    end else begin : g_mid
      assign w_out_rdy = g_stage[s+1].w_in_rdy;
    end

    or_tree_stage #(
      .IN_W   (IN_W),
      .LEVELS (LV)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   (w_in),
      .in_valid_i  (w_in_vld),
      .in_ready_o  (w_in_rdy),
      .out_data_o  (w_out),
      .out_valid_o (w_out_vld),
      .out_ready_i (w_out_rdy)
    );
  end

`ifdef OR_REDUCE_PIPE_STICKY_EN
  logic sticky_q;
  logic sticky_d;

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 1'b0;
    end
    if (bus.out_valid && bus.out_ready && bus.out_x) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_x = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_or_reduce_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_or_reduce_pipe: scoreboard bench for WIDTH=16/LPS=2 and WIDTH=5/LPS=1   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_or_reduce_pipe;

  typedef struct packed {
    logic x;
    int   cyc;
    logic lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  logic a_lat;
  logic b_lat;
  exp_t qa[$];
  exp_t qb[$];

  or_reduce_pipe_if #(.WIDTH(16)) ifa ();
  or_reduce_pipe_if #(.WIDTH(5))  ifb ();

`ifdef OR_REDUCE_PIPE_STICKY_EN
  logic sticky_clr;
  logic sticky_x;
  logic sticky_clr_b;
  logic sticky_x_b;
`endif

  or_reduce_pipe #(.WIDTH(16), .LEVELS_PER_STAGE(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
`ifdef OR_REDUCE_PIPE_STICKY_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_x   (sticky_x)
`endif
  );

  or_reduce_pipe #(.WIDTH(5), .LEVELS_PER_STAGE(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
`ifdef OR_REDUCE_PIPE_STICKY_EN
    ,
    .sticky_clr (sticky_clr_b),
    .sticky_x   (sticky_x_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the result is 1 iff any of the low w bits is set.
  function automatic logic ref_or(input logic [15:0] d, input int w);
    logic any;
    any = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (d[i]) any = 1'b1;
    end
    return any;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'h0;
      1:       return 16'h1 << $urandom_range(0, 15);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] rnd5();
    case ($urandom_range(0, 3))
      0:       return 5'h0;
      1:       return 5'h1 << $urandom_range(0, 4);
      default: return 5'($urandom);
    endcase
  endfunction

  // Inputs are set at posedge+1; transfers are recorded before the next edge.
  task automatic tick();
    exp_t e;
    #1;
    if (ifa.in_valid && ifa.in_ready) begin
      e.x = ref_or(ifa.in_data, 16); e.cyc = cyc; e.lat = a_lat;
      qa.push_back(e);
    end
    if (ifb.in_valid && ifb.in_ready) begin
      e.x = ref_or({11'h0, ifb.in_data}, 5); e.cyc = cyc; e.lat = b_lat;
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    a_lat = 1'b0; b_lat = 1'b0;
  endtask

  task automatic drain();
    idle_all();
    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("drain_a_empty", qa.size(), 0);
    chk("drain_b_empty", qb.size(), 0);
  endtask

  // Monitors: pop on every output transfer, and hold stalled outputs steady.
  initial begin : mon_a
    logic stall, stall_x;
    exp_t e;
    stall = 1'b0; stall_x = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("a_stall_valid", ifa.out_valid, 1);
          chk("a_stall_x", ifa.out_x, stall_x);
        end
        if (ifa.out_valid && ifa.out_ready) begin
          if (qa.size() == 0) begin
            chk("a_extra_out", ifa.out_valid, 0);
          end else begin
            e = qa.pop_front();
            chk("a_out_x", ifa.out_x, e.x);
            if (e.lat) chk("a_latency", cyc - e.cyc, 2);
          end
        end
        stall   = ifa.out_valid && !ifa.out_ready;
        stall_x = ifa.out_x;
      end
    end
  end

  initial begin : mon_b
    logic stall, stall_x;
    exp_t e;
    stall = 1'b0; stall_x = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("b_stall_valid", ifb.out_valid, 1);
          chk("b_stall_x", ifb.out_x, stall_x);
        end
        if (ifb.out_valid && ifb.out_ready) begin
          if (qb.size() == 0) begin
            chk("b_extra_out", ifb.out_valid, 0);
          end else begin
            e = qb.pop_front();
            chk("b_out_x", ifb.out_x, e.x);
            if (e.lat) chk("b_latency", cyc - e.cyc, 3);
          end
        end
        stall   = ifb.out_valid && !ifb.out_ready;
        stall_x = ifb.out_x;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] va [4];
    logic [4:0]  vb [3];
    va[0] = 16'h0000; va[1] = 16'h8000; va[2] = 16'h0001; va[3] = 16'h0000;
    vb[0] = 5'h10;    vb[1] = 5'h00;    vb[2] = 5'h1F;
    n_tests = 0;
    n_fail  = 0;
`ifdef OR_REDUCE_PIPE_STICKY_EN
    sticky_clr = 1'b0;
    sticky_clr_b = 1'b0;
`endif
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", ifa.out_valid, 0);
    chk("rst_a_out_x",     ifa.out_x,     0);
    chk("rst_a_in_ready",  ifa.in_ready,  1);
    chk("rst_b_out_valid", ifb.out_valid, 0);
    chk("rst_b_out_x",     ifb.out_x,     0);
    chk("rst_b_in_ready",  ifb.in_ready,  1);
    rst = 1'b0;
    #1;
    chk("rel_a_in_ready",  ifa.in_ready,  1);
    chk("rel_a_out_valid", ifa.out_valid, 0);

    // Directed streaming, out_ready held high
    a_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = va[i]; tick();
    end
    idle_all();
    b_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifb.in_valid = 1'b1; ifb.in_data = vb[i]; tick();
    end
    drain();

    // Random traffic, no backpressure: exact latency checked
    a_lat = 1'b1; b_lat = 1'b1;
    repeat (60) begin
      ifa.in_valid = ($urandom_range(0, 3) != 0); ifa.in_data = rnd16();
      ifb.in_valid = ($urandom_range(0, 3) != 0); ifb.in_data = rnd5();
      tick();
    end
    drain();

    // Random traffic with backpressure
    repeat (300) begin
      ifa.in_valid = ($urandom_range(0, 3) != 0); ifa.in_data = rnd16();
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      ifb.in_valid = ($urandom_range(0, 3) != 0); ifb.in_data = rnd5();
      ifb.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Backpressure on A: both stages fill, input blocked
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 16'h0010; tick();
    ifa.in_data = 16'h0000; tick();
    ifa.in_data = 16'hFFFF;
    repeat (5) begin
      chk("a_bp_in_ready", ifa.in_ready, 0);
      chk("a_bp_out_x",    ifa.out_x,    1);
      tick();
    end
    drain();

    // Bubble collapse on B (S=3)
    ifb.out_ready = 1'b0;
    ifb.in_valid = 1'b1; ifb.in_data = 5'h04; tick();
    ifb.in_valid = 1'b0;
    repeat (3) tick();
    chk("b_bubble_out_valid", ifb.out_valid, 1);
    chk("b_bubble_in_ready",  ifb.in_ready,  1);
    ifb.in_valid = 1'b1; ifb.in_data = 5'h00; tick();
    ifb.in_valid = 1'b0;
    repeat (2) tick();
    chk("b_bubble_in_ready2", ifb.in_ready, 1);
    drain();

    // Reset with two results in flight on A
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 16'hFFFF; tick(); tick();
    ifa.in_valid = 1'b0;
    chk("mid_pre_out_valid", ifa.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", ifa.out_valid, 0);
    chk("mid_rst_in_ready",  ifa.in_ready,  1);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready",  ifa.in_ready,  1);
    chk("mid_rel_out_valid", ifa.out_valid, 0);
    idle_all();
    repeat (8) tick();
    drain();

`ifdef OR_REDUCE_PIPE_STICKY_EN
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("sticky_cleared", sticky_x, 0);
    ifa.in_valid = 1'b1; ifa.in_data = 16'h0000; tick();
    drain(); tick();
    chk("sticky_zero_no_set", sticky_x, 0);
    ifa.in_valid = 1'b1; ifa.in_data = 16'h0100; tick();
    drain(); tick();
    chk("sticky_set", sticky_x, 1);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("sticky_clr", sticky_x, 0);
    ifa.in_valid = 1'b1; ifa.in_data = 16'h8000; tick();
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 10 && !ifa.out_valid; i++) tick();
    chk("sticky_wait_valid", ifa.out_valid, 1);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("sticky_set_wins", sticky_x, 1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
